ifetch_stage: RTL and testbench

//  PC generator plus IF1->IF2 fetch front end for the 6-stage BRAM pipeline (IF1,IF2,ID,EX,LS,WB).

---
 rtl/fetch_pkg.sv | 15 +
 rtl/ifetch_hold_buf.sv | 52 +++++
 rtl/ifetch_stage.sv | 108 ++++++++++
 tb/tb_ifetch_stage.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

  // IF2 data source: empty, straight from BRAM, or from the hold register
  typedef enum logic [1:0] {
    BUBBLE,
    LIVE,
    HELD
  } fetch_state_t;

  localparam logic [31:0] NOP              = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

endpackage

// File: rtl/ifetch_hold_buf.sv
// IF2 instruction buffer: tracks whether the BRAM output still belongs to the
// IF2 PC, latches the word on the first stall cycle, and muxes inst_if2.
module ifetch_hold_buf
  import fetch_pkg::*;
#(
  parameter logic [31:0] NOP_INST = NOP
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        advance,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_if2
);

  fetch_state_t state_q, state_d;
  logic [31:0]  hold_q, hold_d;

  // State and hold register, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= BUBBLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // Next state, hold capture and instruction output mux
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    inst_if2 = NOP_INST;
    case (state_q)
      LIVE:    inst_if2 = imem_rdata;
      HELD:    inst_if2 = hold_q;
      default: inst_if2 = NOP_INST;
    endcase
    if (flush) begin
      state_d = BUBBLE;
    end else if (advance) begin
      state_d = LIVE;
    end else if (stall && state_q == LIVE) begin
      // BRAM re-reads after this edge, so this is the last cycle the word is on imem_rdata
      state_d = HELD;
      hold_d  = imem_rdata;
    end
  end

endmodule

// File: rtl/ifetch_stage.sv
// PC generator and IF1->IF2 register for the 6-stage BRAM pipeline.
// Optional statistics counters enabled by defining FETCH_STAT_EN.
module ifetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          ADDR_W   = 12,
  parameter logic [31:0] NOP_INST = NOP
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              pc_set,
  input  logic [31:0]       pc_set_target,
  input  logic              pc_stall,
  input  logic              IF1_IF2_stall,
  input  logic              IF1_IF2_flush,
  input  logic              IF2_ID_stall,
  input  logic              IF2_ID_flush,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       pc_if2,
  output logic [31:0]       inst_if2,
  output logic              valid_if2,
  output logic [31:0]       stat_fetch,
  output logic [31:0]       stat_flush
);

  logic [31:0] pc_if1;
  logic [31:0] pc_next;
  logic        advance;

  assign advance   = ~IF1_IF2_flush & ~IF1_IF2_stall;
  assign imem_addr = pc_if1[ADDR_W+1:2];

  // Next PC: redirect beats stall; sequential step wraps modulo 2^32
  always_comb begin
    pc_next = pc_if1 + PC_STEP;
    if (pc_set) begin
      pc_next = pc_set_target & ~32'd3;
    end else if (pc_stall) begin
      pc_next = pc_if1;
    end
  end

  // PC register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pc_if1 <= RESET_PC;
    end else begin
      pc_if1 <= pc_next;
    end
  end

  // IF1/IF2 register: flush > stall > advance
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pc_if2    <= '0;
      valid_if2 <= 1'b0;
    end else if (IF1_IF2_flush) begin
      valid_if2 <= 1'b0;
    end else if (!IF1_IF2_stall) begin
      pc_if2    <= pc_if1;
      valid_if2 <= 1'b1;
    end
  end

  ifetch_hold_buf #(
    .NOP_INST (NOP_INST)
  ) u_hold_buf (
    .clk        (clk),
    .rstn       (rstn),
    .advance    (advance),
    .stall      (IF1_IF2_stall),
    .flush      (IF1_IF2_flush),
    .imem_rdata (imem_rdata),
    .inst_if2   (inst_if2)
  );

`ifdef FETCH_STAT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] flush_cnt;

  // Delivered and killed instruction counters
  always_ff @(posedge clk) begin
    if (!rstn) begin
      fetch_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (valid_if2 && !IF2_ID_stall && !IF2_ID_flush) begin
        fetch_cnt <= fetch_cnt + 32'd1;
      end
      if (valid_if2 && (IF1_IF2_flush || IF2_ID_flush)) begin
        flush_cnt <= flush_cnt + 32'd1;
      end
    end
  end

  assign stat_fetch = fetch_cnt;
  assign stat_flush = flush_cnt;
`else
  logic stat_unused;

  assign stat_unused = IF2_ID_stall ^ IF2_ID_flush;
  assign stat_fetch  = '0;
  assign stat_flush  = '0;
`endif

endmodule

// File: tb/tb_ifetch_stage.sv
// Self-checking bench for ifetch_stage: directed vector table plus randomized
// traffic checked against a PC/IF2-occupancy reference model.
module tb_ifetch_stage;

  localparam logic [31:0] NOPW = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rstn;
  logic        pc_set;
  logic [31:0] pc_set_target;
  logic        pc_stall;
  logic        IF1_IF2_stall;
  logic        IF1_IF2_flush;
  logic        IF2_ID_stall;
  logic        IF2_ID_flush;
  logic [11:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic [31:0] pc_if2;
  logic [31:0] inst_if2;
  logic        valid_if2;
  logic [31:0] stat_fetch;
  logic [31:0] stat_flush;

  logic [31:0] mem [0:4095];

  int compared   = 0;
  int mismatched = 0;

  // Reference model: PC in IF1, occupancy/PC of IF2, counters
  logic [31:0] m_pc1, m_pc2, m_fetch, m_flush;
  logic        m_v;

  ifetch_stage #(
    .RESET_PC (32'h8000_0000),
    .ADDR_W   (12),
    .NOP_INST (NOPW)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .pc_set        (pc_set),
    .pc_set_target (pc_set_target),
    .pc_stall      (pc_stall),
    .IF1_IF2_stall (IF1_IF2_stall),
    .IF1_IF2_flush (IF1_IF2_flush),
    .IF2_ID_stall  (IF2_ID_stall),
    .IF2_ID_flush  (IF2_ID_flush),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .pc_if2        (pc_if2),
    .inst_if2      (inst_if2),
    .valid_if2     (valid_if2),
    .stat_fetch    (stat_fetch),
    .stat_flush    (stat_flush)
  );

  always #5 clk = ~clk;

  // Synchronous-read BRAM, one-cycle latency
  always @(posedge clk) imem_rdata <= mem[imem_addr];

  typedef struct {
    logic        rstn;
    logic        ps;
    logic [31:0] tgt;
    logic        pst, s12, f12, s2, f2;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] einst;
    logic [11:0] eaddr;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic ps, input logic [31:0] tgt,
                              input logic pst, input logic s12, input logic f12,
                              input logic s2, input logic f2, input logic ev,
                              input logic [31:0] epc, input logic [31:0] einst,
                              input logic [11:0] eaddr);
    vec_t v;
    v.rstn = r; v.ps = ps; v.tgt = tgt; v.pst = pst; v.s12 = s12; v.f12 = f12;
    v.s2 = s2; v.f2 = f2; v.ev = ev; v.epc = epc; v.einst = einst; v.eaddr = eaddr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of controls, clock it, advance the model, compare
  task automatic step(input logic r, input logic ps, input logic [31:0] tgt,
                      input logic pst, input logic s12, input logic f12,
                      input logic s2, input logic f2);
    logic [31:0] exp_inst;
    rstn = r; pc_set = ps; pc_set_target = tgt; pc_stall = pst;
    IF1_IF2_stall = s12; IF1_IF2_flush = f12; IF2_ID_stall = s2; IF2_ID_flush = f2;
    @(posedge clk);
    if (!r) begin
      m_pc1 = 32'h8000_0000; m_pc2 = '0; m_v = 1'b0; m_fetch = '0; m_flush = '0;
    end else begin
`ifdef FETCH_STAT_EN
      if (m_v && !s2 && !f2) m_fetch = m_fetch + 1;
      if (m_v && (f12 || f2)) m_flush = m_flush + 1;
`endif
      if (f12) m_v = 1'b0;
      else if (!s12) begin m_pc2 = m_pc1; m_v = 1'b1; end
      if (ps) m_pc1 = {tgt[31:2], 2'b00};
      else if (!pst) m_pc1 = m_pc1 + 32'd4;
    end
    #1;
    // A live IF2 slot always shows the memory word at its own PC
    exp_inst = m_v ? mem[m_pc2[13:2]] : NOPW;
    chk("model_valid", {31'b0, valid_if2}, {31'b0, m_v});
    chk("model_pc_if2", pc_if2, m_pc2);
    chk("model_inst", inst_if2, exp_inst);
    chk("model_addr", {20'b0, imem_addr}, {20'b0, m_pc1[13:2]});
    chk("model_stat_fetch", stat_fetch, m_fetch);
    chk("model_stat_flush", stat_flush, m_flush);
  endtask

  vec_t vt [17];

  initial begin
    logic [31:0] flush_before;
    for (int i = 0; i < 4096; i++) mem[i] = i + 1;
    m_pc1 = 32'h8000_0000; m_pc2 = '0; m_v = 1'b0; m_fetch = '0; m_flush = '0;

    //           rstn ps  tgt            pst s12 f12 s2 f2  ev  pc_if2         inst      addr
    vt[0]  = mk(0, 0, 32'h0,          0, 0, 0, 0, 0, 0, 32'h0,          NOPW,     12'h000);
    vt[1]  = mk(1, 0, 32'h0,          0, 0, 0, 0, 0, 1, 32'h8000_0000, 32'd1,    12'h001);
    vt[2]  = mk(1, 0, 32'h0,          0, 0, 0, 0, 0, 1, 32'h8000_0004, 32'd2,    12'h002);
    vt[3]  = mk(1, 0, 32'h0,          0, 0, 0, 0, 0, 1, 32'h8000_0008, 32'd3,    12'h003);
    vt[4]  = mk(1, 0, 32'h0,          1, 1, 0, 1, 0, 1, 32'h8000_0008, 32'd3,    12'h003);
    vt[5]  = mk(1, 0, 32'h0,          1, 1, 0, 1, 0, 1, 32'h8000_0008, 32'd3,    12'h003);
    vt[6]  = mk(1, 0, 32'h0,          1, 1, 0, 1, 0, 1, 32'h8000_0008, 32'd3,    12'h003);
    vt[7]  = mk(1, 0, 32'h0,          0, 0, 0, 0, 0, 1, 32'h8000_000C, 32'd4,    12'h004);
    vt[8]  = mk(1, 1, 32'h8000_0103, 0, 0, 0, 0, 0, 1, 32'h8000_0010, 32'd5,    12'h040);
    vt[9]  = mk(1, 0, 32'h0,          0, 0, 0, 0, 0, 1, 32'h8000_0100, 32'h41,   12'h041);
    vt[10] = mk(1, 1, 32'h8000_0200, 0, 0, 1, 0, 1, 0, 32'h8000_0100, NOPW,     12'h080);
    vt[11] = mk(1, 0, 32'h0,          0, 0, 0, 0, 0, 1, 32'h8000_0200, 32'h81,   12'h081);
    vt[12] = mk(1, 0, 32'h0,          1, 1, 0, 1, 0, 1, 32'h8000_0200, 32'h81,   12'h081);
    vt[13] = mk(0, 0, 32'h0,          1, 1, 0, 1, 0, 0, 32'h0,          NOPW,     12'h000);
    vt[14] = mk(1, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 1, 32'h8000_0000, 32'd1,    12'hFFF);
    vt[15] = mk(1, 0, 32'h0,          0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 32'h1000, 12'h000);
    vt[16] = mk(1, 0, 32'h0,          0, 0, 0, 0, 0, 1, 32'h0000_0000, 32'd1,    12'h001);

    flush_before = '0;
    for (int i = 0; i < 17; i++) begin
      if (i == 10) flush_before = stat_flush;
      step(vt[i].rstn, vt[i].ps, vt[i].tgt, vt[i].pst, vt[i].s12, vt[i].f12, vt[i].s2, vt[i].f2);
      chk($sformatf("vec%0d_valid", i), {31'b0, valid_if2}, {31'b0, vt[i].ev});
      chk($sformatf("vec%0d_pc_if2", i), pc_if2, vt[i].epc);
      chk($sformatf("vec%0d_inst", i), inst_if2, vt[i].einst);
      chk($sformatf("vec%0d_addr", i), {20'b0, imem_addr}, {20'b0, vt[i].eaddr});
      if (i == 10) begin
`ifdef FETCH_STAT_EN
        chk("flush_count_step", stat_flush, flush_before + 32'd1);
`else
        chk("flush_count_off", stat_flush, flush_before);
`endif
      end
      if (i == 13) begin
        chk("reset_stat_fetch", stat_fetch, 32'h0);
        chk("reset_stat_flush", stat_flush, 32'h0);
      end
    end

    // Randomized traffic over a random memory image, entered through reset
    for (int i = 0; i < 4096; i++) mem[i] = $urandom;
    step(0, 0, 32'h0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      logic r, ps, pst, s12, f12, s2, f2;
      logic [31:0] tgt;
      r   = ($urandom_range(0, 99) >= 2);
      ps  = ($urandom_range(0, 9) == 0);
      tgt = $urandom;
      s12 = ($urandom_range(0, 3) == 0);
      pst = s12 ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 9) == 0);
      f12 = ($urandom_range(0, 9) == 0);
      s2  = s12 ? 1'b1 : ($urandom_range(0, 19) == 0);
      f2  = ($urandom_range(0, 9) == 0);
      step(r, ps, tgt, pst, s12, f12, s2, f2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
